// File: rtl/spi_slave_pkg.sv
// Shared state encoding, command codes and parity helper for spi_slave_param.
// Parity support is enabled in the design by defining SPI_PARITY_EN.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        READ_WAIT,
        READ_TX,
        DONE
    } state_e;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    localparam int PAR_MAXW = 64;

    // Bit that makes the total number of ones odd; zero-extension is harmless.
    function automatic logic odd_par(input logic [PAR_MAXW-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/spi_slave_param_piso.sv
// Load/shift-out register driving miso during read-back, MSB first.
// Register content is zero whenever no word is being shifted out.
module spi_piso_tx #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         bit_o,
    output logic         done_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_o  = sreg_q[W-1];
    assign done_o = (cnt_q == CW'(W - 1));

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            sreg_d = data_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            cnt_d = cnt_q + CW'(1);
            if (done_o) begin
                sreg_d = '0;
            end else begin
                sreg_d = sreg_q << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised clk-sampled SPI slave bridging to the RAM command interface.
// Define SPI_PARITY_EN to add odd-parity bits to received frames and read-back.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ss_n,
    input  logic                mosi,
    output logic                miso,
    output logic [DATA_W+1:0]   rx_data,
    output logic                rx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid,
    output logic                frame_err,
    output logic                busy
);

    localparam int FRAME_W = DATA_W + 2;
`ifdef SPI_PARITY_EN
    localparam int NBITS = FRAME_W + 1;
    localparam int TXW   = DATA_W + 1;
`else
    localparam int NBITS = FRAME_W;
    localparam int TXW   = DATA_W;
`endif
    localparam int CW = $clog2(NBITS + 1);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               rd_pending_q, rd_pending_d;
    logic [TW-1:0]      tmo_q, tmo_d;

    logic               piso_load, piso_shift, piso_clear;
    logic               piso_done, piso_bit;
    logic [TXW-1:0]     tx_word;
    logic               last_bit, par_bit, par_ok;

`ifdef SPI_PARITY_EN
    assign tx_word  = {tx_data, odd_par(PAR_MAXW'(tx_data))};
    assign par_bit  = (cnt_q == CW'(FRAME_W));
    assign last_bit = par_bit;
    assign par_ok   = (mosi == odd_par(PAR_MAXW'(rx_data_q)));
`else
    assign tx_word  = tx_data;
    assign par_bit  = 1'b0;
    assign last_bit = (cnt_q == CW'(FRAME_W - 1));
    assign par_ok   = 1'b1;
`endif

    spi_piso_tx #(
        .W(TXW)
    ) u_piso (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (piso_load),
        .shift_i(piso_shift),
        .clear_i(piso_clear),
        .data_i (tx_word),
        .bit_o  (piso_bit),
        .done_o (piso_done)
    );

    assign miso      = piso_bit;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        rd_pending_d = rd_pending_q;
        tmo_d        = tmo_q;
        piso_load    = 1'b0;
        piso_shift   = 1'b0;
        piso_clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!ss_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                cnt_d = '0;
                if (ss_n) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (!mosi) begin
                    state_d = WRITE;
                end else if (rd_pending_q) begin
                    state_d = READ_DATA;
                end else begin
                    state_d = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (ss_n) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!par_bit) begin
                        rx_data_d = {rx_data_q[FRAME_W-2:0], mosi};
                    end
                    if (last_bit && !par_ok) begin
                        frame_err_d = 1'b1;
                        state_d     = DONE;
                    end else if (last_bit) begin
                        rx_valid_d = 1'b1;
                        state_d    = DONE;
                        if (state_q == READ_ADD) rd_pending_d = 1'b1;
                        if (state_q == READ_DATA) begin
                            state_d = READ_WAIT;
                            tmo_d   = '0;
                        end
                    end
                end
            end
            READ_WAIT: begin
                if (ss_n) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (tx_valid) begin
                    piso_load = 1'b1;
                    state_d   = READ_TX;
                end else if (tmo_q == TW'(TX_TIMEOUT - 1)) begin
                    frame_err_d  = 1'b1;
                    rd_pending_d = 1'b0;
                    state_d      = DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            READ_TX: begin
                // An interrupted read-back still consumes the pending read.
                if (ss_n) begin
                    frame_err_d  = 1'b1;
                    rd_pending_d = 1'b0;
                    piso_clear   = 1'b1;
                    state_d      = IDLE;
                end else begin
                    piso_shift = 1'b1;
                    if (piso_done) begin
                        rd_pending_d = 1'b0;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                if (ss_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_pending_q <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            rd_pending_q <= rd_pending_d;
            tmo_q        <= tmo_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed and randomised frames for spi_slave_param against a frame-level model.
// Honours SPI_PARITY_EN (16-bit payload with parity when defined).
module tb_spi_slave_param;

`ifdef SPI_PARITY_EN
    localparam int DW  = 16;
    localparam bit PAR = 1'b1;
`else
    localparam int DW  = 8;
    localparam bit PAR = 1'b0;
`endif
    localparam int FW  = DW + 2;
    localparam int NB  = FW + (PAR ? 1 : 0);
    localparam int NO  = DW + (PAR ? 1 : 0);
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ss_n = 1'b1;
    logic          mosi = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          miso, rx_valid, frame_err, busy;
    logic [FW-1:0] rx_data;

    int nchk = 0;
    int nerr = 0;
    bit pending = 1'b0;

    spi_slave_param #(
        .DATA_W    (DW),
        .TX_TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input logic s, input logic m, input logic v);
        ss_n     = s;
        mosi     = m;
        tx_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic par_of(input logic [63:0] v);
        return ($countones(v) % 2) == 0;
    endfunction

    task automatic end_frame();
        step(1'b1, 1'b0, 1'b0);
        chk("busy_end", busy, 1'b0);
    endtask

    task automatic do_frame(input bit sel, input logic [FW-1:0] frame,
                            input int abort_at, input bit par_bad,
                            input int txdelay, input logic [DW-1:0] txd,
                            input int rst_tx);
        logic [NB-1:0] bits;
        logic [NO-1:0] obits;
        bit is_rd;
        bit bad;
        is_rd = sel && pending;
        bad   = PAR && par_bad;
`ifdef SPI_PARITY_EN
        bits  = {frame, par_of(64'(frame)) ^ par_bad};
        obits = {txd, par_of(64'(txd))};
`else
        bits  = frame;
        obits = txd;
`endif
        step(1'b0, 1'($urandom), 1'b0);
        chk("busy_start", busy, 1'b1);
        step(1'b0, sel, 1'b0);
        for (int i = 0; i < NB; i++) begin
            if (i == abort_at) begin
                step(1'b1, bits[NB-1-i], 1'b0);
                chk("abort_err", frame_err, 1'b1);
                chk("abort_rxv", rx_valid, 1'b0);
                chk("abort_busy", busy, 1'b0);
                step(1'b1, 1'b0, 1'b0);
                chk("abort_pulse", frame_err, 1'b0);
                return;
            end
            step(1'b0, bits[NB-1-i], 1'b0);
            if (i < NB - 1) chk("mid_rxv", rx_valid, 1'b0);
        end
        if (bad) begin
            chk("par_err", frame_err, 1'b1);
            chk("par_rxv", rx_valid, 1'b0);
            end_frame();
            return;
        end
        chk("rx_valid", rx_valid, 1'b1);
        chk("rx_data", rx_data, frame);
        chk("no_err", frame_err, 1'b0);
        if (!is_rd) begin
            if (sel) pending = 1'b1;
            tx_data = '1;
            step(1'b0, 1'($urandom), 1'b1);
            chk("rxv_pulse", rx_valid, 1'b0);
            chk("probe_miso", miso, 1'b0);
            chk("busy_done", busy, 1'b1);
            end_frame();
            return;
        end
        if (txdelay >= TMO) begin
            for (int k = 1; k < TMO; k++) begin
                step(1'b0, 1'($urandom), 1'b0);
                chk("tmo_early", frame_err, 1'b0);
            end
            step(1'b0, 1'b0, 1'b0);
            chk("tmo_err", frame_err, 1'b1);
            chk("tmo_miso", miso, 1'b0);
            pending = 1'b0;
            end_frame();
            return;
        end
        for (int k = 0; k < txdelay; k++) begin
            step(1'b0, 1'($urandom), 1'b0);
            chk("wait_miso", miso, 1'b0);
        end
        tx_data = txd;
        step(1'b0, 1'($urandom), 1'b1);
        for (int i = 0; i < NO; i++) begin
            if (i == rst_tx) begin
                rst_n = 1'b0;
                step(1'b1, 1'b0, 1'b0);
                chk("rst_miso", miso, 1'b0);
                chk("rst_rxv", rx_valid, 1'b0);
                chk("rst_err", frame_err, 1'b0);
                chk("rst_busy", busy, 1'b0);
                rst_n   = 1'b1;
                pending = 1'b0;
                return;
            end
            chk("miso_bit", miso, obits[NO-1-i]);
            tx_data = DW'($urandom);
            step(1'b0, 1'($urandom), 1'($urandom));
        end
        chk("miso_idle", miso, 1'b0);
        chk("tx_err", frame_err, 1'b0);
        pending = 1'b0;
        end_frame();
    endtask

    initial begin
        bit            sel;
        logic [FW-1:0] fr;
        int            ab, dly, rt;
        bit            pb;
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("reset_miso", miso, 1'b0);
        chk("reset_rxv", rx_valid, 1'b0);
        chk("reset_err", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rxd", rx_data, '0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);

        do_frame(1'b0, {2'b00, DW'(8'hA5)}, -1, 1'b0, 0, '0, -1);
        do_frame(1'b1, {2'b10, DW'(8'h03)}, -1, 1'b0, 0, '0, -1);
        do_frame(1'b1, {2'b11, DW'(8'h00)}, -1, 1'b0, 2, DW'(16'h00C3), -1);
        do_frame(1'b1, {2'b10, DW'(8'h5A)}, 6, 1'b0, 0, '0, -1);
        do_frame(1'b1, {2'b10, DW'(8'h11)}, -1, 1'b0, 0, '0, -1);
        do_frame(1'b1, {2'b11, DW'(8'h00)}, -1, 1'b0, TMO, '0, -1);
        do_frame(1'b1, {2'b10, DW'(8'h22)}, -1, 1'b0, 0, '0, -1);
        do_frame(1'b1, {2'b11, DW'(8'h00)}, -1, 1'b0, 1, DW'(16'hB7E1), 3);
        do_frame(1'b1, {2'b10, DW'(8'h44)}, NB - 1, 1'b0, 0, '0, -1);
        do_frame(1'b0, {2'b01, DW'(16'hBEEF)}, -1, 1'b1, 0, '0, -1);
        do_frame(1'b0, {2'b01, DW'(16'h1234)}, -1, 1'b0, 0, '0, -1);
        do_frame(1'b1, {2'b10, DW'(8'h7F)}, -1, 1'b0, 0, '0, -1);
        do_frame(1'b1, {2'b11, DW'(8'h00)}, -1, 1'b0, TMO - 1,
                 DW'(16'h8001), -1);

        for (int n = 0; n < 40; n++) begin
            sel = 1'($urandom);
            fr  = FW'({$urandom, $urandom});
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            pb  = ($urandom_range(0, 3) == 0);
            dly = int'($urandom_range(0, TMO));
            rt  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NO - 1)) : -1;
            do_frame(sel, fr, ab, pb, dly, DW'($urandom), rt);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised successor to the team's fixed 10-bit SPI slave.
- Bridges a clk-sampled serial link (ss_n/mosi/miso) to the single-port RAM command interface.
- Adds:
  - generic data width
  - rx_valid as a one-cycle pulse
  - tracked read-address/read-data pairing
  - MSB-first read-back with a tx_valid timeout
  - abort detection via frame_err

Parameters:
DATA_W, 8, data/address payload width; frame width FRAME_W = DATA_W+2 (2-bit command + payload)
TX_TIMEOUT, 16, clk cycles to wait for tx_valid in a read-data frame before abort (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  reset, synchronous, active-low
ss_n  in  1  slave select, active-low
mosi  in  1  serial input, sampled each posedge while ss_n=0
miso  out  1  serial output, registered
rx_data  out  FRAME_W  received frame {cmd[1:0], payload}, MSB first
rx_valid  out  1  one-cycle pulse: rx_data complete and stable
tx_data  in  DATA_W  read data from RAM
tx_valid  in  1  tx_data valid (single-cycle or held)
frame_err  out  1  one-cycle pulse on abort or timeout
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, rd_pending=0, state IDLE; applies mid-frame too (frame discarded, no pulses).
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, READ_TX, DONE.
- IDLE -> CHK_CMD when ss_n=0.
- CHK_CMD samples selector bit on mosi:
  - 0 -> WRITE
  - 1 and rd_pending=0 -> READ_ADD
  - 1 and rd_pending=1 -> READ_DATA
- WRITE, READ_ADD and READ_DATA each shift exactly FRAME_W bits, MSB first, into rx_data.
  - Counter width $clog2(FRAME_W+1).
  - rx_data holds its last value outside shifting.
- rx_valid: 1 in the cycle after the last bit is sampled, then 0.
- After rx_valid:
  - WRITE -> DONE.
  - READ_ADD sets rd_pending and -> DONE.
  - READ_DATA -> READ_WAIT.
- READ_WAIT captures tx_data on the first cycle tx_valid=1 -> READ_TX.
  - If TX_TIMEOUT cycles elapse without tx_valid: frame_err pulse, rd_pending cleared, -> DONE.
- READ_TX drives miso = tx_data[DATA_W-1] down to [0], one bit per cycle (DATA_W cycles).
  - Then clears rd_pending, miso=0, -> DONE.
- DONE ignores mosi until ss_n=1 -> IDLE. miso=0 in every state except READ_TX.
- ss_n=1 in CHK_CMD, mid-shift, READ_WAIT or READ_TX:
  - frame_err pulse; no rx_valid; -> IDLE next cycle.
  - rd_pending unchanged, except an aborted READ_TX clears it.
- ss_n=1 in the same cycle as the last shift bit: the frame counts as aborted; that bit is not taken.
- Command bits in rx_data are passed through unchecked; the RAM decodes them.
- tx_valid outside READ_WAIT is ignored.
- Back-to-back frames: a minimum of one IDLE cycle with ss_n=1 is required.

Optional Feature:
- Macro SPI_PARITY_EN.
- Defined:
  - Every shifted frame carries one extra odd-parity bit after the payload.
  - Parity mismatch -> frame_err instead of rx_valid; rd_pending not updated.
  - READ_TX appends an odd-parity bit over tx_data after bit 0 (DATA_W+1 cycles).
- Undefined: no parity bits; timing exactly as above.

Decomposition:
- Package spi_slave_pkg:
  - state enum (3-bit)
  - command codes WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11
  - function for odd parity
- One natural sub-module: spi_piso_tx, a DATA_W-bit load/shift-out register with bit counter and done flag, instantiated for READ_TX.

Test Plan:
- Write: ss_n=0, mosi 0 then 10'b00_1010_0101 -> rx_valid one cycle after last bit, rx_data=10'h0A5, busy until ss_n=1.
- Read pair: selector 1 + 10'b10_0000_0011 -> rx_valid, rd_pending=1. Next frame: selector 1 + 10'b11_0000_0000, tx_valid with tx_data=8'hC3 two cycles after rx_valid -> miso 1,1,0,0,0,0,1,1 on consecutive cycles.
- Abort: ss_n high after 4 payload bits -> frame_err one cycle, rx_valid never asserted, next selector-1 frame still goes to READ_ADD.
- Timeout: READ_DATA frame, tx_valid held 0 -> frame_err exactly TX_TIMEOUT cycles after entering READ_WAIT, miso stays 0, rd_pending=0.
- Reset mid-READ_TX: rst_n=0 for one cycle -> miso=0, rx_valid=0, frame_err=0, busy=0 next cycle.
- DATA_W=16 with SPI_PARITY_EN: wrong parity bit -> frame_err, no rx_valid. Correct parity -> rx_valid, rx_data=18-bit frame.
